// File: rtl/ascii_pkg.sv
// rtl/ascii_pkg.sv - ASCII control codes shared by the UART receiver and the character buffer.
package ascii_pkg;

  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_DEL = 8'h7F;
  localparam logic [7:0] ASCII_ESC = 8'h1B;

  // Host keys onto the buffer's control codes: Enter gives a newline, Backspace gives delete.
  function automatic logic [7:0] ascii_translate(input logic [7:0] b);
    case (b)
      ASCII_CR: ascii_translate = ASCII_LF;
      ASCII_BS: ascii_translate = ASCII_DEL;
      default:  ascii_translate = b;
    endcase
  endfunction

endpackage

// File: rtl/synchronizer.sv
// rtl/synchronizer.sv - two-flop CDC cell for an asynchronous input pin, reset value selectable.
module synchronizer #(
  parameter logic p_rst_val = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= p_rst_val;
      q    <= p_rst_val;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver producing translated ASCII write strobes for the character buffer.
// Defining UART_RX_PARITY_EN switches the frame from 8N1 to 8E1.
module uart_rx #(
  parameter int p_clk_freq = 25_000_000,
  parameter int p_baud     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] ascii,
  output logic       ascii_val,
  output logic       frame_err
);
  import ascii_pkg::*;

  localparam int N  = p_clk_freq / p_baud;
  localparam int CW = (N < 4) ? 2 : $clog2(N);
  localparam logic [CW-1:0] CNT_HALF = CW'(N / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  if (N < 4) begin : g_bad_rate
    $error("uart_rx: bit period below 4 clock cycles");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [2:0]      idx, idx_next;
  logic [7:0]      shreg, shreg_next;
  logic [7:0]      ascii_next;
  logic            val_next, err_next;
  logic            perr, perr_next;
  logic            rx_s;

  synchronizer #(.p_rst_val(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      perr      <= 1'b0;
      ascii     <= 8'h00;
      ascii_val <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      idx       <= idx_next;
      shreg     <= shreg_next;
      perr      <= perr_next;
      ascii     <= ascii_next;
      ascii_val <= val_next;
      frame_err <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt + CW'(1);
    idx_next   = idx;
    shreg_next = shreg;
    perr_next  = perr;
    ascii_next = ascii;
    val_next   = 1'b0;
    err_next   = 1'b0;

    case (state)
      IDLE: begin
        cnt_next = '0;
        if (!rx_s) state_next = START;
      end

      // A start bit that is high again at mid-bit was only a glitch.
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_next   = '0;
          idx_next   = '0;
          perr_next  = 1'b0;
          state_next = rx_s ? IDLE : DATA;
        end
      end

      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_next   = '0;
          shreg_next = {rx_s, shreg[7:1]};
          idx_next   = idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_next   = '0;
          perr_next  = ^{shreg, rx_s};
          state_next = STOP;
        end
      end
`endif

      // A low stop bit may be a break; hold off until the line returns high.
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_next = '0;
          if (rx_s && !perr) begin
            ascii_next = ascii_translate(shreg);
            val_next   = 1'b1;
          end else begin
            err_next = 1'b1;
          end
          state_next = rx_s ? IDLE : WAIT_IDLE;
        end
      end

      WAIT_IDLE: begin
        cnt_next = '0;
        if (rx_s) state_next = IDLE;
      end

      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with N = 10 cycles per bit.
module tb_uart_rx;

  localparam int N = 10;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2 + N / 2 + 10 * N + 1;
`else
  localparam int LAT = 2 + N / 2 + 9 * N + 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] ascii;
  logic       ascii_val;
  logic       frame_err;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         t0;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   val_cnt = 0;
  int   err_cnt = 0;

  uart_rx #(.p_clk_freq(1000), .p_baud(100)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .ascii     (ascii),
    .ascii_val (ascii_val),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] model_xlate(input logic [7:0] b);
    if (b == 8'h0D) return 8'h0A;
    if (b == 8'h08) return 8'h7F;
    return b;
  endfunction

  always @(negedge clk) begin
    if (rst && (ascii_val || frame_err)) begin
      if (ascii_val) val_cnt++;
      if (frame_err) err_cnt++;
      check("strobe_excl", {31'd0, ascii_val & frame_err}, 32'd0);
      if (sbq.size() == 0) begin
        check("spurious_strobe", {30'd0, ascii_val, frame_err}, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("strobe_kind", {31'd0, frame_err}, {31'd0, e.is_err});
        if (!e.is_err) check("ascii", {24'd0, ascii}, {24'd0, e.data});
        check("latency", cyc - e.t0, LAT);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input int stop_low,
                            input bit exp_err);
    exp_t e;
    e.is_err = exp_err;
    e.data   = model_xlate(d);
    e.t0     = cyc;
    sbq.push_back(e);
    rx = 1'b0;
    wait_cycles(N);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cycles(N);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    wait_cycles(N);
`else
    if (par) rx = 1'b0;
`endif
    if (stop_low > 0) begin
      rx = 1'b0;
      wait_cycles(stop_low);
    end
    rx = 1'b1;
    wait_cycles(N);
  endtask

  task automatic send_ok(input logic [7:0] d);
    send_frame(d, ^d, 0, 1'b0);
  endtask

  task automatic drain();
    int k = 0;
    while (sbq.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("drain", sbq.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    rx  = 1'b1;
    wait_cycles(4);
    check("rst_ascii", {24'd0, ascii}, 32'h00);
    check("rst_val", {31'd0, ascii_val}, 32'd0);
    check("rst_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b1;

    wait_cycles(200);
    check("idle_val_cnt", val_cnt, 32'd0);
    check("idle_err_cnt", err_cnt, 32'd0);
    check("idle_ascii", {24'd0, ascii}, 32'h00);

    send_ok(8'h41);
    drain();

    // Back-to-back frames with translated control codes.
    send_ok(8'h0D);
    send_ok(8'h08);
    send_ok(8'h1B);
    send_ok(8'h0A);
    send_ok(8'h7F);
    drain();
    check("hold_ascii", {24'd0, ascii}, 32'h7F);

    // Break: stop bit held low for 3N.
    send_frame(8'h55, ^8'h55, 3 * N, 1'b1);
    send_ok(8'h32);
    drain();
    check("err_cnt_break", err_cnt, 32'd1);

    // Short glitch must not start a frame.
    rx = 1'b0;
    wait_cycles(3);
    rx = 1'b1;
    wait_cycles(2 * N);
    send_ok(8'h33);
    drain();

    // Reset asserted in the middle of data bit 4.
    begin
      logic [7:0] d;
      int v0;
      d  = 8'h41;
      v0 = val_cnt;
      rx = 1'b0;
      wait_cycles(N);
      for (int i = 0; i < 4; i++) begin
        rx = d[i];
        wait_cycles(N);
      end
      rx = d[4];
      wait_cycles(N / 2);
      rst = 1'b0;
      rx  = 1'b1;
      wait_cycles(3);
      check("midrst_ascii", {24'd0, ascii}, 32'h00);
      check("midrst_val", {31'd0, ascii_val}, 32'd0);
      check("midrst_err", {31'd0, frame_err}, 32'd0);
      rst = 1'b1;
      wait_cycles(15 * N);
      check("midrst_no_strobe", val_cnt, v0);
    end
    send_ok(8'h5A);
    drain();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h41, 1'b1, 0, 1'b1);
    send_ok(8'h34);
    drain();
`endif

    wait_cycles(2 * N);
    check("sb_empty", sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that turns a UART byte stream from the host into single-cycle ASCII write strobes for the character buffer. It drives the buffer's `ascii`/`ascii_val` write port. Received bytes are mapped onto the buffer's control codes: carriage return becomes LF and backspace becomes DEL. The block sits between the board RX pin and the character buffer, in the VGA pixel-clock domain.

## Interface
- `p_clk_freq`, default 25_000_000: clock frequency in Hz.
- `p_baud`, default 115200: line rate in baud.
- Derived: `N = p_clk_freq / p_baud`, integer division, is the bit period in cycles. It is elaborated as a localparam, and elaboration fails if N < 4.
- `clk`  input  1  system clock. One clock only.
- `rst`  input  1  synchronous, active-low reset. The block is in reset while `rst == 0` at a rising edge.
- `rx`  input  1  asynchronous serial line. Idle is high. Frame format is 8N1, LSB first.
- `ascii`  output  8  received byte after translation. Valid only while `ascii_val` is high.
- `ascii_val`  output  1  one-cycle strobe: write `ascii` into the buffer.
- `frame_err`  output  1  one-cycle strobe: a bad stop bit (or bad parity) was received.

## Operation
- `rx` passes through a 2-flop synchronizer, and both flops reset to 1. All logic below uses the synchronized value `rx_s`.
- FSM states are IDLE, START, DATA, STOP, WAIT_IDLE.
- Bit-period counter `cnt` is ceil(log2(N)) bits wide. Bit index `idx` is 3 bits.
- IDLE
  - On `rx_s == 0`: clear `cnt` and go to START.
- START
  - At `cnt == N/2 - 1`, sample `rx_s`.
  - If `rx_s == 0`: clear `cnt`, clear `idx`, go to DATA.
  - If `rx_s == 1`: treat it as a glitch and return to IDLE. No strobe.
- DATA
  - At `cnt == N - 1`, shift `rx_s` into the MSB of the shift register (LSB-first reception) and clear `cnt`.
  - After `idx == 7`, go to STOP (or to PARITY, see Configuration).
- STOP
  - At `cnt == N - 1`, sample `rx_s`.
  - If `rx_s == 1`: register the translated byte, pulse `ascii_val`, go to IDLE.
  - If `rx_s == 0`: pulse `frame_err` and go to WAIT_IDLE. `ascii_val` stays low.
- WAIT_IDLE
  - Remain here while `rx_s == 0`, which covers a break condition.
  - Go to IDLE on the first `rx_s == 1`.
- Translation, applied in the STOP accept cycle:
  - 0x0D → 0x0A
  - 0x08 → 0x7F
  - All other bytes pass unchanged, including 0x0A, 0x1B and 0x7F.
- `ascii` holds its last value between strobes.

## Timing
- Reset values:
  - `ascii = 8'h00`, `ascii_val = 0`, `frame_err = 0`
  - state = IDLE, `cnt = 0`, `idx = 0`, synchronizer flops = 1
- Reset mid-frame abandons the frame with no strobe.
  - After reset, a line that is still low is seen as a new start bit.
- Sample points are measured from the first cycle `rx_s` is low:
  - Start-bit check: N/2 cycles later.
  - Data bit k: N/2 + (k+1)·N cycles later.
  - Stop bit: N/2 + 9·N cycles later.
- Strobe latency: `ascii_val`/`frame_err` are registered and assert the cycle after the stop-bit sample. Pin-to-strobe latency is 2 (synchronizer) + N/2 + 9N + 1 cycles.
- Strobes are exactly one cycle wide. At most one strobe per frame, and `ascii_val` and `frame_err` are never high together.
- Back-to-back frames: the FSM is back in IDLE in the cycle after the stop sample. A start edge arriving from the following cycle onward is accepted, so there are no dead bit periods.
- The write port has no backpressure. The character buffer accepts a write every cycle.

## Configuration
- `UART_RX_PARITY_EN`
  - Defined: frame is 8E1. A PARITY state sits between DATA and STOP and samples at `cnt == N - 1`. If XOR(data, parity bit) ≠ 0, the frame completes through STOP but ends with a `frame_err` pulse instead of `ascii_val`. Stop-bit sample point moves to N/2 + 10·N. Latency grows by N.
  - Undefined: frame is 8N1 and there is no PARITY state.

## Structure
- Shared package `ascii_pkg`:
  - Constants `ASCII_LF` (0x0A), `ASCII_CR` (0x0D), `ASCII_BS` (0x08), `ASCII_DEL` (0x7F), `ASCII_ESC` (0x1B).
  - These are also used by the character buffer.
- The FSM state enum is local to `uart_rx`.
- Sub-module `synchronizer`: a 2-flop CDC cell with a reset-value parameter. It is reused for any other asynchronous pin.

## Test plan
All scenarios use `p_clk_freq = 1000`, `p_baud = 100`, so N = 10.
- After reset, hold `rx = 1` for 200 cycles → `ascii_val` and `frame_err` stay 0, and `ascii = 0x00`.
- Send 0x41 ('A') → one `ascii_val` pulse with `ascii = 0x41`, 2 + 5 + 90 + 1 = 98 cycles after the falling edge.
- Send 0x0D, then 0x08, back to back → strobes carry 0x0A and 0x7F. 0x1B passes as 0x1B.
- Send 0x55 with the stop bit forced low for 3N → one `frame_err` pulse and no `ascii_val`. A following 0x32 ('2') is received correctly.
- Drive a 3-cycle low glitch on `rx` → no strobe, and the FSM is back in IDLE; the next 0x33 ('3') frame is received correctly.
- Pull `rst` low during bit 4 of a frame → outputs return to their reset values, and no strobe is seen for that frame. With `UART_RX_PARITY_EN`, 0x41 with parity bit 1 → `frame_err` only.
